// File: rtl/pulse_indicator.sv
// Stretches single-cycle events into human-visible blinks: each event yields one
// ON_TICKS-long high pulse followed by an OFF_TICKS-long low gap, with overflow queued.
module pulse_indicator #(
    parameter int WIDTH     = 18,
    parameter int ON_TICKS  = 4,
    parameter int OFF_TICKS = 2,
    parameter int PEND_W    = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in,
    output logic              out,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              dropped
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    localparam logic [7:0]        ON_LAST  = 8'(ON_TICKS - 1);
    localparam logic [7:0]        OFF_LAST = 8'(OFF_TICKS - 1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_prescaler;
    logic [7:0]         r_tick_cnt;
    logic               r_out;
    logic               r_busy;
    logic [PEND_W-1:0]  r_pending;
    logic               r_dropped;

    logic w_tick;
    logic w_on_done;
    logic w_gap_done;
    logic w_full;

    assign w_tick     = (r_prescaler == '1);
    assign w_on_done  = w_tick && (r_tick_cnt == ON_LAST);
    assign w_gap_done = w_tick && (r_tick_cnt == OFF_LAST);
    assign w_full     = (r_pending == PEND_MAX);

    assign out     = r_out;
    assign busy    = r_busy;
    assign pending = r_pending;
    assign dropped = r_dropped;

    // Prescaler and tick counter restart on every state entry so each phase has exact length.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_prescaler <= '0;
            r_tick_cnt  <= '0;
            r_out       <= 1'b0;
            r_busy      <= 1'b0;
            r_pending   <= '0;
            r_dropped   <= 1'b0;
        end else begin
            r_dropped   <= 1'b0;
            r_prescaler <= r_prescaler + 1'b1;
            if (w_tick) begin
                r_tick_cnt <= r_tick_cnt + 8'd1;
            end

            case (r_state)
                S_IDLE: begin
                    if (in) begin
                        r_state     <= S_ON;
                        r_out       <= 1'b1;
                        r_busy      <= 1'b1;
                        r_prescaler <= '0;
                        r_tick_cnt  <= '0;
                    end
                end

                S_ON: begin
                    if (in) begin
                        if (w_full) begin
                            r_dropped <= 1'b1;
                        end else begin
                            r_pending <= r_pending + 1'b1;
                        end
                    end
                    if (w_on_done) begin
                        r_state     <= S_GAP;
                        r_out       <= 1'b0;
                        r_prescaler <= '0;
                        r_tick_cnt  <= '0;
                    end
                end

                S_GAP: begin
                    if (w_gap_done) begin
                        r_prescaler <= '0;
                        r_tick_cnt  <= '0;
                        if (r_pending != '0) begin
                            // A simultaneous event replaces the one being dequeued.
                            r_state <= S_ON;
                            r_out   <= 1'b1;
                            if (!in) begin
                                r_pending <= r_pending - 1'b1;
                            end
                        end else if (in) begin
                            r_state <= S_ON;
                            r_out   <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else if (in) begin
                        if (w_full) begin
                            r_dropped <= 1'b1;
                        end else begin
                            r_pending <= r_pending + 1'b1;
                        end
                    end
                end

                default: begin
                    r_state     <= S_IDLE;
                    r_out       <= 1'b0;
                    r_busy      <= 1'b0;
                    r_pending   <= '0;
                    r_prescaler <= '0;
                    r_tick_cnt  <= '0;
                end
            endcase
        end
    end

endmodule
